// File: rtl/mc_maindec.sv
// Moore main-control FSM for the multicycle MIPS datapath, plus a retired-instruction counter.
// Optional build macro MAINDEC_ILLEGAL_TRAP_EN: undefined opcodes lock the FSM in TRAP and set illegal.
module mc_maindec #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  output logic             iord,
  output logic             irwrite,
  output logic             memwrite,
  output logic             regwrite,
  output logic             regdst,
  output logic             memtoreg,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic             zeroext,
  output logic [2:0]       aluop,
  output logic [1:0]       pcsrc,
  output logic             pcwrite,
  output logic             branch,
  output logic             branchne,
  output logic [CNT_W-1:0] retired,
  output logic             illegal
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB,
    BEQEX, BNEEX, ADDIEX, ANDIEX, ORIEX, IMMWB, JEX, TRAP
  } state_t;

  typedef struct packed {
    logic       iord;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       zeroext;
    logic [2:0] aluop;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       branch;
    logic       branchne;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_t           state_q, state_d;
  ctrl_t            ctrl_q;
  logic [CNT_W-1:0] retired_q;
  logic             retire_d;

  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.irwrite = 1'b1;
        c.alusrcb = 2'b01;
        c.pcwrite = 1'b1;
      end
      DECODE:  c.alusrcb = 2'b11;
      MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      MEMRD:   c.iord = 1'b1;
      MEMWB: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
      end
      MEMWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      RTYPEEX: begin
        c.alusrca = 1'b1;
        c.aluop   = 3'b010;
      end
      RTYPEWB: begin
        c.regwrite = 1'b1;
        c.regdst   = 1'b1;
      end
      BEQEX, BNEEX: begin
        c.alusrca  = 1'b1;
        c.aluop    = 3'b001;
        c.pcsrc    = 2'b01;
        c.branch   = (s == BEQEX);
        c.branchne = (s == BNEEX);
      end
      ADDIEX, ANDIEX, ORIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
        c.zeroext = (s != ADDIEX);
        c.aluop   = (s == ANDIEX) ? 3'b100 : (s == ORIEX) ? 3'b011 : 3'b000;
      end
      IMMWB:   c.regwrite = 1'b1;
      JEX: begin
        c.pcsrc   = 2'b10;
        c.pcwrite = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // retire_d marks the edge that leaves the last state of an instruction.
  always_comb begin
    state_d  = FETCH;
    retire_d = 1'b0;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_BNE:       state_d = BNEEX;
          OP_ADDI:      state_d = ADDIEX;
          OP_ANDI:      state_d = ANDIEX;
          OP_ORI:       state_d = ORIEX;
          OP_J:         state_d = JEX;
          default: begin
`ifdef MAINDEC_ILLEGAL_TRAP_EN
            state_d  = TRAP;
`else
            state_d  = FETCH;
            retire_d = 1'b1;
`endif
          end
        endcase
      end
      MEMADR:  state_d = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   state_d = MEMWB;
      RTYPEEX: state_d = RTYPEWB;
      ADDIEX, ANDIEX, ORIEX: state_d = IMMWB;
      MEMWB, MEMWR, RTYPEWB, IMMWB, BEQEX, BNEEX, JEX: begin
        state_d  = FETCH;
        retire_d = 1'b1;
      end
`ifdef MAINDEC_ILLEGAL_TRAP_EN
      TRAP:    state_d = TRAP;
`endif
      default: state_d = FETCH;
    endcase
  end

  // Control outputs are registered alongside the state from the decoded next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= FETCH;
      ctrl_q    <= decode(FETCH);
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= decode(state_d);
      if (retire_d) retired_q <= retired_q + CNT_W'(1);
    end
  end

`ifdef MAINDEC_ILLEGAL_TRAP_EN
  logic illegal_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                illegal_q <= 1'b0;
    else if (state_d == TRAP)  illegal_q <= 1'b1;
  end
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  // Write enables are gated by reset so nothing commits while it is held low.
  assign irwrite  = ctrl_q.irwrite  & reset;
  assign memwrite = ctrl_q.memwrite & reset;
  assign regwrite = ctrl_q.regwrite & reset;
  assign pcwrite  = ctrl_q.pcwrite  & reset;
  assign branch   = ctrl_q.branch   & reset;
  assign branchne = ctrl_q.branchne & reset;
  assign iord     = ctrl_q.iord;
  assign regdst   = ctrl_q.regdst;
  assign memtoreg = ctrl_q.memtoreg;
  assign alusrca  = ctrl_q.alusrca;
  assign alusrcb  = ctrl_q.alusrcb;
  assign zeroext  = ctrl_q.zeroext;
  assign aluop    = ctrl_q.aluop;
  assign pcsrc    = ctrl_q.pcsrc;
  assign retired  = retired_q;

endmodule

// File: doc/mc_maindec.md
Name: mc_maindec

Overview:
- Moore-style main control FSM for the multicycle MIPS datapath.
- Sequences fetch, decode, execute, memory and writeback one state per clock.
- Drives datapath enables and mux selects, and the 3-bit aluop consumed by the ALU decoder.
- Counts retired instructions for bring-up visibility.

Parameters:
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
op  input  6  instr[31:26], valid from DECODE onward (IR stable)
iord  output  1  memory address select: 0 = PC, 1 = ALUOut
irwrite  output  1  instruction register load
memwrite  output  1  data memory write strobe
regwrite  output  1  register file write
regdst  output  1  write-register select: 0 = rt, 1 = rd
memtoreg  output  1  writeback select: 0 = ALUOut, 1 = MDR
alusrca  output  1  ALU A select: 0 = PC, 1 = rs
alusrcb  output  2  ALU B select: 00 = rt, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm<<2
zeroext  output  1  immediate extender uses zero-extension (andi/ori)
aluop  output  3  000 add, 001 sub, 010 R-type (use funct), 011 or, 100 and
pcsrc  output  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
pcwrite  output  1  unconditional PC write
branch  output  1  PC write if zero == 1 (beq)
branchne  output  1  PC write if zero == 0 (bne)
retired  output  CNT_W  count of completed instructions
illegal  output  1  sticky undefined-opcode flag (see Optional Feature)

Behaviour:
- Reset low: state <= FETCH, retired <= 0, illegal <= 0, asynchronously.
- While reset is low, write enables are forced 0: pcwrite, irwrite, memwrite, regwrite, branch, branchne.
- While reset is low, every other output shows its FETCH value.
- Reset deasserting mid-instruction aborts that instruction; the next rising edge evaluates from FETCH.
- Outputs are a pure function of state. Any output not listed for a state is 0.
- States and outputs:
  - FETCH: iord=0, irwrite=1, alusrca=0, alusrcb=01, aluop=000, pcsrc=00, pcwrite=1. Next: DECODE.
  - DECODE: alusrca=0, alusrcb=11, aluop=000 (branch target into ALUOut). Next is chosen by op:
    - 100011 (lw) or 101011 (sw) -> MEMADR
    - 000000 -> RTYPEEX
    - 000100 -> BEQEX
    - 000101 -> BNEEX
    - 001000 -> ADDIEX
    - 001100 -> ANDIEX
    - 001101 -> ORIEX
    - 000010 -> JEX
    - other -> see Optional Feature
  - MEMADR: alusrca=1, alusrcb=10, aluop=000. Next: MEMRD if lw, MEMWR if sw.
  - MEMRD: iord=1. Next: MEMWB.
  - MEMWB: regwrite=1, regdst=0, memtoreg=1. Next: FETCH.
  - MEMWR: iord=1, memwrite=1. Next: FETCH.
  - RTYPEEX: alusrca=1, alusrcb=00, aluop=010. Next: RTYPEWB.
  - RTYPEWB: regwrite=1, regdst=1, memtoreg=0. Next: FETCH.
  - BEQEX: alusrca=1, alusrcb=00, aluop=001, pcsrc=01, branch=1. Next: FETCH.
  - BNEEX: same as BEQEX but branchne=1 instead of branch. Next: FETCH.
  - ADDIEX: alusrca=1, alusrcb=10, aluop=000. Next: IMMWB.
  - ANDIEX: alusrca=1, alusrcb=10, zeroext=1, aluop=100. Next: IMMWB.
  - ORIEX: alusrca=1, alusrcb=10, zeroext=1, aluop=011. Next: IMMWB.
  - IMMWB: regwrite=1, regdst=0, memtoreg=0. Next: FETCH.
  - JEX: pcsrc=10, pcwrite=1. Next: FETCH.
- Instruction latencies in cycles, counted from FETCH: lw 5, sw 4, R-type 4, addi/andi/ori 4, beq/bne 3, j 3.
- retired increments by 1 on every clock edge that leaves a terminal state:
  - Terminal states: MEMWB, MEMWR, RTYPEWB, IMMWB, BEQEX, BNEEX, JEX.
  - Increments regardless of branch outcome.
  - Wraps modulo 2^CNT_W with no saturation.
- Unreachable state encodings recover to FETCH on the next edge.

Optional Feature:
- Macro: MAINDEC_ILLEGAL_TRAP_EN.
- Defined:
  - An undefined opcode in DECODE moves the FSM to TRAP.
  - TRAP drives all write enables 0 and stays in TRAP until reset.
  - illegal <= 1 on entry to TRAP and holds until reset.
  - retired does not increment.
- Undefined:
  - An undefined opcode in DECODE returns to FETCH (NOP, 2 cycles); retired increments.
  - illegal is tied to 0.

Test Plan:
- Reset low for 3 cycles, release, op=100011 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH. regwrite=1 and memtoreg=1 only in cycle 5. retired=1 after that edge.
- op=000000 -> RTYPEEX shows aluop=010, alusrcb=00; RTYPEWB shows regdst=1, regwrite=1. Total 4 cycles; retired +1.
- op=001101 -> ORIEX shows aluop=011, zeroext=1, alusrcb=10. op=001100 -> ANDIEX shows aluop=100. Each finishes through IMMWB in 4 cycles.
- op=000100, then op=000101 -> BEQEX shows branch=1, pcsrc=01, aluop=001; BNEEX shows branchne=1, branch=0. 3 cycles each; retired +2 total.
- op=000010 -> JEX shows pcwrite=1, pcsrc=10. Assert reset in MEMRD of a following lw -> state=FETCH immediately, write enables 0, retired=0.
- op=111111 -> with MAINDEC_ILLEGAL_TRAP_EN: TRAP, illegal=1, no enables for 10 cycles. Without the macro: FETCH after DECODE, illegal=0, retired +1.
